// File: rtl/readout_pkg.sv
// readout_pkg: shared encodings, phase lengths and exposure limits
// for the readout timer slice.
package readout_pkg;

  typedef enum logic [1:0] {
    MS_IDLE     = 2'b00,
    MS_EXPOSURE = 2'b01,
    MS_READOUT  = 2'b10,
    MS_ILLEGAL  = 2'b11
  } main_state_e;

  typedef enum logic [2:0] {
    RD_INIT    = 3'b000,
    RD_NRE_1   = 3'b001,
    RD_ADC_1   = 3'b010,
    RD_NOTHING = 3'b011,
    RD_NRE_2   = 3'b100,
    RD_ADC_2   = 3'b101,
    RD_END     = 3'b110,
    RD_UNUSED  = 3'b111
  } rd_phase_e;

  localparam logic [2:0] T_NRE = 3'd2;
  localparam logic [2:0] T_ADC = 3'd2;
  localparam logic [2:0] T_GAP = 3'd1;

  localparam logic [4:0] EXP_MIN = 5'd2;
  localparam logic [4:0] EXP_MAX = 5'd30;
  localparam logic [4:0] EXP_DEF = 5'd15;

  // The illegal main-state code behaves as IDLE.
  function automatic main_state_e decode_main(
    input logic [1:0] raw
  );
    if (raw == 2'b11) return MS_IDLE;
    return main_state_e'(raw);
  endfunction

  // Cycles spent in a timed phase; untimed phases report 1.
  function automatic logic [2:0] phase_len(
    input rd_phase_e p
  );
    logic [2:0] len;
    len = 3'd1;
    case (p)
      RD_NRE_1, RD_NRE_2: len = T_NRE;
      RD_ADC_1, RD_ADC_2: len = T_ADC;
      RD_NOTHING:         len = T_GAP;
      default:            len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/readout_timer_counter.sv
// rd_phase_counter: counts cycles spent in the current readout phase.
// Ports: clk_i, rst_i (sync, active-high), clr_i (restart at 0),
//        len_i (phase length), tc_o (last cycle of the phase).
module rd_phase_counter
  import readout_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic [2:0] len_i,
  output logic       tc_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Saturate so a long END phase never wraps into a false tc.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (cnt_q != 3'd7) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == (len_i - 3'd1));

endmodule

// File: rtl/readout_timer.sv
// readout_timer: exposure countdown, exposure-length register and
// readout phase sequencer driven by the main control state.
// Ports: i_Clock, i_Reset (sync, active-high), i_Main_FSM (2b),
//        i_Exp_Inc, i_Exp_Dec (level), o_count_time (5b),
//        o_RD_FSM (3b), o_Exp_Time (5b).
// Build option: READOUT_EXP_ADJUST_EN enables Inc/Dec adjustment;
// otherwise the exposure length is fixed at EXP_DEF.
module readout_timer
  import readout_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [1:0] i_Main_FSM,
  input  logic       i_Exp_Inc,
  input  logic       i_Exp_Dec,
  output logic [4:0] o_count_time,
  output logic [2:0] o_RD_FSM,
  output logic [4:0] o_Exp_Time
);

  main_state_e main_s;
  assign main_s = decode_main(i_Main_FSM);

  logic [4:0] exp_w;

`ifdef READOUT_EXP_ADJUST_EN
  logic       inc_q;
  logic       dec_q;
  logic       inc_rise;
  logic       dec_rise;
  logic [4:0] exp_q;
  logic [4:0] exp_d;

  assign inc_rise = i_Exp_Inc & ~inc_q;
  assign dec_rise = i_Exp_Dec & ~dec_q;

  // Coincident edges cancel; limits saturate.
  always_comb begin
    exp_d = exp_q;
    if (main_s == MS_IDLE) begin
      if (inc_rise && !dec_rise && exp_q < EXP_MAX) begin
        exp_d = exp_q + 5'd1;
      end else if (dec_rise && !inc_rise && exp_q > EXP_MIN) begin
        exp_d = exp_q - 5'd1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      exp_q <= EXP_DEF;
    end else begin
      inc_q <= i_Exp_Inc;
      dec_q <= i_Exp_Dec;
      exp_q <= exp_d;
    end
  end

  assign exp_w = exp_q;
`else
  logic unused_exp_in;
  assign unused_exp_in = i_Exp_Inc ^ i_Exp_Dec;
  assign exp_w = EXP_DEF;
`endif

  assign o_Exp_Time = exp_w;

  rd_phase_e  rd_q;
  rd_phase_e  rd_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic       ph_tc;
  logic       ph_clr;

  always_comb begin
    rd_d = rd_q;
    if (main_s != MS_READOUT) begin
      rd_d = RD_INIT;
    end else begin
      case (rd_q)
        RD_INIT:    rd_d = RD_NRE_1;
        RD_NRE_1:   if (ph_tc) rd_d = RD_ADC_1;
        RD_ADC_1:   if (ph_tc) rd_d = RD_NOTHING;
        RD_NOTHING: if (ph_tc) rd_d = RD_NRE_2;
        RD_NRE_2:   if (ph_tc) rd_d = RD_ADC_2;
        RD_ADC_2:   if (ph_tc) rd_d = RD_END;
        RD_END:     rd_d = RD_END;
        default:    rd_d = RD_INIT;
      endcase
    end
  end

  // Any phase change restarts the duration count.
  assign ph_clr = (rd_d != rd_q);

  rd_phase_counter u_ph_cnt (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .clr_i (ph_clr),
    .len_i (phase_len(rd_q)),
    .tc_o  (ph_tc)
  );

  // IDLE keeps the countdown preloaded for the next exposure.
  always_comb begin
    cnt_d = cnt_q;
    case (main_s)
      MS_IDLE:     cnt_d = exp_w;
      MS_EXPOSURE: if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rd_q  <= RD_INIT;
      cnt_q <= EXP_DEF;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_RD_FSM     = rd_q;
  assign o_count_time = cnt_q;

endmodule

// File: tb/tb_readout_timer.sv
// tb_readout_timer: directed and random stimulus against a cycle model
// built from phase durations and exposure rules.
module tb_readout_timer;

`ifdef READOUT_EXP_ADJUST_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ms;
  logic       inc;
  logic       dec;
  logic [4:0] cnt_o;
  logic [2:0] rd_o;
  logic [4:0] exp_o;

  always #5 clk = ~clk;

  readout_timer dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Main_FSM   (ms),
    .i_Exp_Inc    (inc),
    .i_Exp_Dec    (dec),
    .o_count_time (cnt_o),
    .o_RD_FSM     (rd_o),
    .o_Exp_Time   (exp_o)
  );

  int checks = 0;
  int errors = 0;

  int m_exp;
  int m_cnt;
  int m_ro;
  bit m_pinc;
  bit m_pdec;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase from number of consecutive READOUT edges seen.
  function automatic int phase_of(input int n);
    int dur [5];
    int acc;
    dur = '{2, 2, 1, 2, 2};
    if (n == 0) return 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      acc += dur[i];
      if (n <= acc) return i + 1;
    end
    return 6;
  endfunction

  task automatic model_edge();
    bit ri;
    bit rdn;
    int mm;
    if (rst) begin
      m_exp  = 15;
      m_cnt  = 15;
      m_ro   = 0;
      m_pinc = 0;
      m_pdec = 0;
    end else begin
      ri     = inc && !m_pinc;
      rdn    = dec && !m_pdec;
      m_pinc = inc;
      m_pdec = dec;
      mm     = (ms == 2'b11) ? 0 : int'(ms);
      if (mm == 0) begin
        m_cnt = m_exp;
        m_ro  = 0;
        if (ADJ && ri && !rdn && m_exp < 30) m_exp++;
        if (ADJ && rdn && !ri && m_exp > 2)  m_exp--;
      end else if (mm == 1) begin
        if (m_cnt > 0) m_cnt--;
        m_ro = 0;
      end else begin
        m_ro++;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".cnt"}, int'(cnt_o), m_cnt);
    check({tag, ".rd"},  int'(rd_o),  phase_of(m_ro));
    check({tag, ".exp"}, int'(exp_o), m_exp);
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    step("inc_hi");
    inc = 1'b0;
    step("inc_lo");
  endtask

  task automatic pulse_dec();
    dec = 1'b1;
    step("dec_hi");
    dec = 1'b0;
    step("dec_lo");
  endtask

  int rd_tab [12];

  initial begin
    rd_tab = '{1, 1, 2, 2, 3, 4, 4, 5, 5, 6, 6, 6};
    rst = 1'b1;
    ms  = 2'b00;
    inc = 1'b0;
    dec = 1'b0;
    m_exp = 15; m_cnt = 15; m_ro = 0; m_pinc = 0; m_pdec = 0;

    step("reset");
    step("reset");
    check("rst_cnt", int'(cnt_o), 15);
    check("rst_rd",  int'(rd_o),  0);
    check("rst_exp", int'(exp_o), 15);

    rst = 1'b0;
    step("idle");
    check("idle_cnt", int'(cnt_o), 15);
    check("idle_rd",  int'(rd_o),  0);

    ms = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      step("expo");
      if (i == 1) check("expo_e1", int'(cnt_o), 14);
      if (i >= 15) check("expo_zero", int'(cnt_o), 0);
    end

    ms = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step("ro");
      check("ro_tbl", int'(rd_o), rd_tab[i]);
    end
    ms = 2'b00;
    step("ro_exit");
    check("ro_exit_rd", int'(rd_o), 0);

    for (int i = 0; i < 20; i++) pulse_inc();
    check("inc_max", int'(exp_o), ADJ ? 30 : 15);
    for (int i = 0; i < 40; i++) pulse_dec();
    check("dec_min", int'(exp_o), ADJ ? 2 : 15);
    pulse_inc();
    inc = 1'b1;
    dec = 1'b1;
    step("both_hi");
    inc = 1'b0;
    dec = 1'b0;
    step("both_lo");
    check("both", int'(exp_o), ADJ ? 3 : 15);

    ms = 2'b01;
    step("expo2");
    pulse_inc();
    check("inc_expo", int'(exp_o), ADJ ? 3 : 15);
    ms = 2'b11;
    step("illegal");
    check("illegal_cnt", int'(cnt_o), ADJ ? 3 : 15);

    ms = 2'b10;
    for (int i = 0; i < 6; i++) step("ro2");
    check("ro2_nre2", int'(rd_o), 4);
    rst = 1'b1;
    step("ro_rst");
    check("ro_rst_rd",  int'(rd_o),  0);
    check("ro_rst_cnt", int'(cnt_o), 15);
    rst = 1'b0;
    ms  = 2'b00;
    step("post_rst");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ms = 2'($urandom_range(0, 3));
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
